// File: rtl/mac_accum_n_pkg.sv
// -----------------------------------------------------------------------------
// mac_accum_n_pkg
// Shared constants for the multiply-accumulate stage. The state encodings live
// here so the operand-sequencing controller can decode busy/state from the same
// values the accumulator uses.
// -----------------------------------------------------------------------------
package mac_accum_n_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACCUM = 2'd1;
    localparam logic [STATE_W-1:0] ST_HOLD  = 2'd2;

endpackage : mac_accum_n_pkg

// File: rtl/mac_accum_n_counter.sv
// -----------------------------------------------------------------------------
// down_counter_n
// Loadable down counter that tracks how many products of the current job are
// still outstanding.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   synchronous reset, active-low (count -> 0)
//   load      load load_val (has priority over dec)
//   load_val  value to load
//   dec       decrement by one; ignored when the count is already zero
//   count     current count
//   zero      count == 0
//   one       count == 1 (the next decrement finishes the job)
// -----------------------------------------------------------------------------
module down_counter_n #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         one
);

    // NOTE: reset is sampled inside the clocked block (synchronous), and all
    // state is written with non-blocking assignments so every register sees
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    assign one  = (count == W'(1));

endmodule : down_counter_n

// File: rtl/mac_accum_n.sv
// -----------------------------------------------------------------------------
// mac_accum_n
// Accumulates a programmed number of unsigned products from the registered
// multiplier stage into a wider running sum, then holds the result under a
// valid/ack handshake. All outputs are registers or pure state decodes.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous reset, active-low; aborts any job in flight
//   start      begin a job (only looked at in IDLE)
//   len        number of products in the job, captured with start
//   p_valid    product on p is valid this cycle
//   p          unsigned product (N bits)
//   p_ready    high in ACCUM: a product is accepted when p_valid is also high
//   sum        accumulated result, modulo 2^ACC_W
//   sum_valid  high in HOLD: sum is final and stable
//   sum_ack    consumer has taken sum (only looked at in HOLD)
//   ovf        sticky carry-out of the current job, cleared by start or reset
//   busy       high in ACCUM or HOLD
//
// ACC_W must be >= N.
// -----------------------------------------------------------------------------
module mac_accum_n
    import mac_accum_n_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             p_valid,
    input  logic [N-1:0]     p,
    output logic             p_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ack,
    output logic             ovf,
    output logic             busy
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;

    logic               job_start;
    logic               accept;
    logic               cnt_zero;
    logic               cnt_one;
    logic [CNT_W-1:0]   cnt_value;
    logic [ACC_W:0]     sum_ext;

    assign job_start = (state == ST_IDLE)  && start;
    assign accept    = (state == ST_ACCUM) && p_valid;

    // ---------------------------------------------------------------- counter
    down_counter_n #(
        .W (CNT_W)
    ) u_beats (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (job_start),
        .load_val (len),
        .dec      (accept),
        .count    (cnt_value),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        // NOTE: a default assignment at the top of every combinational block
        // keeps each path fully specified, so no latch can be inferred.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // A zero count here is unreachable; leaving ACCUM keeps the
                // block from waiting forever if it ever happens.
                if (cnt_zero || (accept && cnt_one)) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (sum_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- output decode
    always_comb begin
        p_ready   = (state == ST_ACCUM);
        sum_valid = (state == ST_HOLD);
        busy      = (state != ST_IDLE);
    end

    // --------------------------------------------------------------- datapath
    // One extra bit captures the carry out of the ACC_W-bit sum; the padding
    // width is always at least one because ACC_W >= N.
    assign sum_ext = {1'b0, sum} + {{(ACC_W + 1 - N){1'b0}}, p};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (job_start) begin
            sum <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            sum <= sum_ext[ACC_W-1:0];
            ovf <= ovf | sum_ext[ACC_W];
        end
    end

endmodule : mac_accum_n

// File: tb/tb_mac_accum_n.sv
// -----------------------------------------------------------------------------
// tb_mac_accum_n
// Two instances share one stimulus stream: dut_a with the default ACC_W=12 and
// dut_b with ACC_W=6 so wrap-around and the sticky overflow flag are exercised.
// A job-level reference model (running true total, outstanding beats, two
// flags) predicts both instances every cycle.
// -----------------------------------------------------------------------------
module tb_mac_accum_n;

    localparam int N       = 4;
    localparam int CNT_W   = 4;
    localparam int ACC_W_A = 12;
    localparam int ACC_W_B = 6;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic [CNT_W-1:0]   len;
    logic               p_valid;
    logic [N-1:0]       p;
    logic               sum_ack;

    logic               p_ready_a, sum_valid_a, ovf_a, busy_a;
    logic [ACC_W_A-1:0] sum_a;
    logic               p_ready_b, sum_valid_b, ovf_b, busy_b;
    logic [ACC_W_B-1:0] sum_b;

    int total = 0;
    int bad   = 0;

    mac_accum_n #(.N(N), .ACC_W(ACC_W_A), .CNT_W(CNT_W)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .p_valid   (p_valid),
        .p         (p),
        .p_ready   (p_ready_a),
        .sum       (sum_a),
        .sum_valid (sum_valid_a),
        .sum_ack   (sum_ack),
        .ovf       (ovf_a),
        .busy      (busy_a)
    );

    mac_accum_n #(.N(N), .ACC_W(ACC_W_B), .CNT_W(CNT_W)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .p_valid   (p_valid),
        .p         (p),
        .p_ready   (p_ready_b),
        .sum       (sum_b),
        .sum_valid (sum_valid_b),
        .sum_ack   (sum_ack),
        .ovf       (ovf_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------- reference model
    bit      m_collect;   // job running, still taking products
    bit      m_hold;      // job finished, result waiting for ack
    int      m_rem;       // products still owed to the job
    longint  m_total;     // true (unwrapped) total of the job

    task automatic model_edge(input logic rn, st, input logic [CNT_W-1:0] ln,
                              input logic pv, input logic [N-1:0] pp,
                              input logic ak);
        if (!rn) begin
            m_collect = 0; m_hold = 0; m_rem = 0; m_total = 0;
        end else if (m_collect) begin
            if (pv) begin
                m_total += pp;
                m_rem   -= 1;
                if (m_rem == 0) begin
                    m_collect = 0;
                    m_hold    = 1;
                end
            end
        end else if (m_hold) begin
            if (ak) m_hold = 0;
        end else if (st) begin
            m_total = 0;
            if (ln == 0) begin
                m_hold = 1;
            end else begin
                m_collect = 1;
                m_rem     = ln;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        longint mod_a = 64'd1 << ACC_W_A;
        longint mod_b = 64'd1 << ACC_W_B;
        check("a.p_ready",   32'(p_ready_a),   32'(m_collect));
        check("a.sum_valid", 32'(sum_valid_a), 32'(m_hold));
        check("a.busy",      32'(busy_a),      32'(m_collect | m_hold));
        check("a.sum",       32'(sum_a),       32'(m_total % mod_a));
        check("a.ovf",       32'(ovf_a),       32'(m_total >= mod_a));
        check("b.p_ready",   32'(p_ready_b),   32'(m_collect));
        check("b.sum_valid", 32'(sum_valid_b), 32'(m_hold));
        check("b.busy",      32'(busy_b),      32'(m_collect | m_hold));
        check("b.sum",       32'(sum_b),       32'(m_total % mod_b));
        check("b.ovf",       32'(ovf_b),       32'(m_total >= mod_b));
    endtask

    // Drive one cycle of inputs, clock it, update the model, compare.
    task automatic tick(input logic rn, st, input logic [CNT_W-1:0] ln,
                        input logic pv, input logic [N-1:0] pp,
                        input logic ak);
        reset_n = rn; start = st; len = ln; p_valid = pv; p = pp; sum_ack = ak;
        @(posedge clk);
        model_edge(rn, st, ln, pv, pp, ak);
        #1;
        check_model();
    endtask

    // ------------------------------------------------------- directed table
    typedef struct packed {
        logic               rn;
        logic               st;
        logic [CNT_W-1:0]   ln;
        logic               pv;
        logic [N-1:0]       pp;
        logic               ak;
        logic [ACC_W_A-1:0] e_sum;
        logic               e_sv;
        logic               e_pr;
        logic               e_ovf;
        logic               e_busy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset_n = 1'b0; start = 1'b0; len = '0; p_valid = 1'b0; p = '0; sum_ack = 1'b0;
        m_collect = 0; m_hold = 0; m_rem = 0; m_total = 0;

        //                rn st len pv  p  ak  sum sv pr ovf busy
        // basic job: 5 + 7 + 9
        tbl.push_back('{1'b1,1'b1,4'd3,1'b0,4'd0,1'b0,12'd0, 1'b0,1'b1,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b1,4'd5,1'b0,12'd5, 1'b0,1'b1,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b1,4'd7,1'b0,12'd12,1'b0,1'b1,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b1,4'd9,1'b0,12'd21,1'b1,1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b1,4'd2,1'b0,12'd21,1'b1,1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,12'd21,1'b0,1'b0,1'b0,1'b0});
        // sum_ack in IDLE: no effect
        tbl.push_back('{1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,12'd21,1'b0,1'b0,1'b0,1'b0});
        // zero-length job
        tbl.push_back('{1'b1,1'b1,4'd0,1'b0,4'd0,1'b0,12'd0, 1'b1,1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,12'd0, 1'b0,1'b0,1'b0,1'b0});
        // stalls: len=2, p_valid 1,0,0,1 with p=4 then 6
        tbl.push_back('{1'b1,1'b1,4'd2,1'b0,4'd0,1'b0,12'd0, 1'b0,1'b1,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b1,4'd4,1'b0,12'd4, 1'b0,1'b1,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b0,4'd9,1'b0,12'd4, 1'b0,1'b1,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b0,4'd9,1'b0,12'd4, 1'b0,1'b1,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b1,4'd6,1'b0,12'd10,1'b1,1'b0,1'b0,1'b1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b1,1'b0,4'd0,1'b1,4'd3,1'b0,12'd10,1'b1,1'b0,1'b0,1'b1});
        tbl.push_back('{1'b1,1'b0,4'd0,1'b0,4'd0,1'b1,12'd10,1'b0,1'b0,1'b0,1'b0});

        // reset state
        tick(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b1, 4'd5, 1'b1, 4'd3, 1'b1);
        check("reset.sum",       32'(sum_a),       32'd0);
        check("reset.sum_valid", 32'(sum_valid_a), 32'd0);
        check("reset.p_ready",   32'(p_ready_a),   32'd0);
        check("reset.ovf",       32'(ovf_a),       32'd0);
        check("reset.busy",      32'(busy_a),      32'd0);

        foreach (tbl[i]) begin
            tick(tbl[i].rn, tbl[i].st, tbl[i].ln, tbl[i].pv, tbl[i].pp, tbl[i].ak);
            check($sformatf("tbl%0d.sum", i),       32'(sum_a),       32'(tbl[i].e_sum));
            check($sformatf("tbl%0d.sum_valid", i), 32'(sum_valid_a), 32'(tbl[i].e_sv));
            check($sformatf("tbl%0d.p_ready", i),   32'(p_ready_a),   32'(tbl[i].e_pr));
            check($sformatf("tbl%0d.ovf", i),       32'(ovf_a),       32'(tbl[i].e_ovf));
            check($sformatf("tbl%0d.busy", i),      32'(busy_a),      32'(tbl[i].e_busy));
        end

        // overflow: 15 x 15 = 225; fits 12 bits, wraps to 33 in 6 bits
        tick(1'b1, 1'b1, 4'd15, 1'b0, '0, 1'b0);
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0, '0, 1'b1, 4'd15, 1'b0);
        check("ovf.a_sum",  32'(sum_a),       32'd225);
        check("ovf.a_ovf",  32'(ovf_a),       32'd0);
        check("ovf.b_sum",  32'(sum_b),       32'd33);
        check("ovf.b_ovf",  32'(ovf_b),       32'd1);
        check("ovf.b_sv",   32'(sum_valid_b), 32'd1);
        tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        check("ovf.idle_b_ovf", 32'(ovf_b),  32'd1);
        check("ovf.idle_b_sum", 32'(sum_b),  32'd33);
        check("ovf.idle_busy",  32'(busy_b), 32'd0);
        tick(1'b1, 1'b1, 4'd1, 1'b0, '0, 1'b0);
        check("ovf.cleared_b", 32'(ovf_b), 32'd0);
        check("ovf.cleared_s", 32'(sum_b), 32'd0);
        tick(1'b1, 1'b0, '0, 1'b1, 4'd1, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);

        // reset mid-job after two accepts, then a one-beat job
        tick(1'b1, 1'b1, 4'd4, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1, 4'd8, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1, 4'd8, 1'b0);
        tick(1'b0, 1'b0, '0, 1'b1, 4'd8, 1'b0);
        check("rstmid.sum",   32'(sum_a),       32'd0);
        check("rstmid.pr",    32'(p_ready_a),   32'd0);
        check("rstmid.sv",    32'(sum_valid_a), 32'd0);
        check("rstmid.busy",  32'(busy_a),      32'd0);
        tick(1'b1, 1'b1, 4'd1, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1, 4'd3, 1'b0);
        check("rstmid.job_sum", 32'(sum_a),       32'd3);
        check("rstmid.job_sv",  32'(sum_valid_a), 32'd1);
        tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);

        // start ignored in ACCUM and in HOLD alongside sum_ack
        tick(1'b1, 1'b1, 4'd2, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, 4'd5, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b1, 4'd5, 1'b1, 4'd2, 1'b0);
        tick(1'b1, 1'b0, '0, 1'b1, 4'd2, 1'b0);
        check("ign.len_sv",  32'(sum_valid_a), 32'd1);
        check("ign.len_sum", 32'(sum_a),       32'd4);
        tick(1'b1, 1'b1, 4'd3, 1'b0, '0, 1'b1);
        check("ign.hold_start_busy", 32'(busy_a), 32'd0);
        tick(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        check("ign.still_idle", 32'(busy_a), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 3) == 0),
                 CNT_W'($urandom),
                 ($urandom_range(0, 2) != 0),
                 N'($urandom),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mac_accum_n
